// File: rtl/gpio_pkg.sv
// gpio_pkg: register map, access-size encodings and byte-enable helpers shared by the GPIO block.
package gpio_pkg;
    localparam logic [2:0] GPIO_REG_OUT    = 3'd0;
    localparam logic [2:0] GPIO_REG_IN     = 3'd1;
    localparam logic [2:0] GPIO_REG_EDGE   = 3'd2;
    localparam logic [2:0] GPIO_REG_IRQ_EN = 3'd3;
    localparam logic [2:0] GPIO_REG_SET    = 3'd4;
    localparam logic [2:0] GPIO_REG_CLR    = 3'd5;
    localparam logic [1:0] GPIO_SIZE_BYTE  = 2'd0;
    localparam logic [1:0] GPIO_SIZE_HALF  = 2'd1;
    localparam logic [1:0] GPIO_SIZE_WORD  = 2'd2;

    function automatic logic [3:0] gpio_byte_en(input logic [1:0] size, input logic [1:0] addr);
        return size == GPIO_SIZE_BYTE ? 4'b0001 << addr :
               size == GPIO_SIZE_HALF ? 4'b0011 << addr : 4'b1111;
    endfunction

    function automatic logic [31:0] gpio_be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: accepts a new level on one synchronised input after it has held for DEBOUNCE_CYCLES edges.
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable,
    output logic chg
);
    localparam int W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);
    logic [W-1:0] cnt;
    assign chg = (din != stable) && (cnt == LAST);
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (din == stable) begin
            cnt <= '0;
        end else if (chg) begin
            stable <= din;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/dbus_gpio.sv
// dbus_gpio: dBus GPIO peripheral with outputs, synchronised inputs, sticky edge flags and level irq.
// Define GPIO_DEBOUNCE_EN to insert a per-input debounce filter after the synchroniser.
module dbus_gpio
    import gpio_pkg::*;
#(
    parameter int N_OUT           = 3,
    parameter int N_IN            = 1,
    parameter bit OUT_ACTIVE_LOW  = 1'b1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    input  logic             cmd_wr,
    input  logic [4:0]       cmd_addr,
    input  logic [31:0]      cmd_data,
    input  logic [1:0]       cmd_size,
    output logic             rsp_valid,
    output logic [31:0]      rsp_data,
    output logic [N_OUT-1:0] gpio_out,
    input  logic [N_IN-1:0]  gpio_in,
    output logic             irq
);
    logic [N_IN-1:0]  sync0, sync1, in_stable, chg, edge_flags, irq_en;
    logic [N_OUT-1:0] out_q;
    logic [31:0]      mask, wd, out_nxt, ie_nxt, w1c, rd_data;
    logic [2:0]       ra;
    logic             we, re;
    logic             unused_bits;

    always_comb begin
        mask    = gpio_be_mask(gpio_byte_en(cmd_size, cmd_addr[1:0]));
        wd      = cmd_data & mask;
        ra      = cmd_addr[4:2];
        we      = cmd_valid && cmd_wr;
        re      = cmd_valid && !cmd_wr;
        out_nxt = !we                ? 32'(out_q) :
                  ra == GPIO_REG_OUT ? (32'(out_q) & ~mask) | wd :
                  ra == GPIO_REG_SET ? 32'(out_q) | wd :
                  ra == GPIO_REG_CLR ? 32'(out_q) & ~wd : 32'(out_q);
        ie_nxt  = (we && ra == GPIO_REG_IRQ_EN) ? (32'(irq_en) & ~mask) | wd : 32'(irq_en);
        w1c     = (we && ra == GPIO_REG_EDGE) ? wd : 32'd0;
        rd_data = ra == GPIO_REG_OUT    ? 32'(out_q) :
                  ra == GPIO_REG_IN     ? 32'(in_stable) :
                  ra == GPIO_REG_EDGE   ? 32'(edge_flags) :
                  ra == GPIO_REG_IRQ_EN ? 32'(irq_en) : 32'd0;
    end

    assign unused_bits = ^{out_nxt, ie_nxt, w1c};
    assign gpio_out    = out_q ^ {N_OUT{OUT_ACTIVE_LOW}};

`ifdef GPIO_DEBOUNCE_EN
    for (genvar i = 0; i < N_IN; i++) begin : g_dbn
        gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (sync1[i]),
            .stable (in_stable[i]),
            .chg    (chg[i])
        );
    end
`else
    localparam int unused_dc = DEBOUNCE_CYCLES;
    assign chg = sync1 ^ in_stable;
    always_ff @(posedge clk) begin
        if (!reset_n) in_stable <= '0;
        else          in_stable <= sync1;
    end
`endif

    // A fresh edge wins over a same-cycle W1C so no transition is ever lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync0      <= '0;
            sync1      <= '0;
            out_q      <= '0;
            irq_en     <= '0;
            edge_flags <= '0;
            irq        <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            sync0      <= gpio_in;
            sync1      <= sync0;
            out_q      <= out_nxt[N_OUT-1:0];
            irq_en     <= ie_nxt[N_IN-1:0];
            edge_flags <= (edge_flags & ~w1c[N_IN-1:0]) | chg;
            irq        <= |(edge_flags & irq_en);
            rsp_valid  <= re;
            if (re) rsp_data <= rd_data;
        end
    end
endmodule

// File: tb/tb_dbus_gpio.sv
// tb_dbus_gpio: randomized and directed checks of dbus_gpio against a cycle-level behavioural model.
module tb_dbus_gpio;
    localparam int N_OUT = 3;
    localparam int N_IN  = 1;
    localparam int DC    = 16;
    localparam logic [31:0] OM = (32'd1 << N_OUT) - 1;
    localparam logic [31:0] IM = (32'd1 << N_IN) - 1;

    logic clk = 0;
    logic reset_n = 0;
    logic cmd_valid = 0, cmd_wr = 0;
    logic [4:0] cmd_addr = 0;
    logic [31:0] cmd_data = 0;
    logic [1:0] cmd_size = 2;
    logic rsp_valid;
    logic [31:0] rsp_data;
    logic [N_OUT-1:0] gpio_out;
    logic [N_IN-1:0] gpio_in = 0;
    logic irq;

    int n_cmp = 0, n_err = 0;

    logic [31:0] m_out, m_ie, m_edge, m_st, m_rdata;
    logic        m_irq, m_rvalid;
    logic [31:0] p1, p2;
    int          run [N_IN];

    dbus_gpio #(.N_OUT(N_OUT), .N_IN(N_IN), .OUT_ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .gpio_out(gpio_out),
        .gpio_in(gpio_in), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int r);
        case (r)
            0: return m_out;
            1: return m_st;
            2: return m_edge;
            3: return m_ie;
            default: return 32'd0;
        endcase
    endfunction

    task automatic step();
        logic [31:0] s, ns, mask, d, w1c;
        int r;
        @(posedge clk);
        if (!reset_n) begin
            {m_out, m_ie, m_edge, m_st, m_rdata, p1, p2} = '0;
            m_irq = 0;
            m_rvalid = 0;
            foreach (run[i]) run[i] = 0;
        end else begin
            s  = p2;
            p2 = p1;
            p1 = 32'(gpio_in);
            ns = m_st;
            for (int i = 0; i < N_IN; i++) begin
`ifdef GPIO_DEBOUNCE_EN
                if (s[i] != m_st[i]) begin
                    run[i]++;
                    if (run[i] == DC) begin
                        ns[i] = s[i];
                        run[i] = 0;
                    end
                end else run[i] = 0;
`else
                ns[i] = s[i];
`endif
            end
            r    = int'(cmd_addr) / 4;
            mask = cmd_size == 0 ? 32'hFF << (8 * (cmd_addr % 4)) :
                   cmd_size == 1 ? 32'hFFFF << (8 * (cmd_addr % 4)) : 32'hFFFF_FFFF;
            d    = cmd_data & mask;
            w1c  = 0;
            m_rvalid = cmd_valid && !cmd_wr;
            if (m_rvalid) m_rdata = model_read(r);
            m_irq = (m_edge & m_ie) != 0;
            if (cmd_valid && cmd_wr) begin
                case (r)
                    0: m_out = ((m_out & ~mask) | d) & OM;
                    2: w1c = d;
                    3: m_ie = ((m_ie & ~mask) | d) & IM;
                    4: m_out = (m_out | d) & OM;
                    5: m_out = m_out & ~d;
                    default: ;
                endcase
            end
            m_edge = ((m_edge & ~w1c) | (ns ^ m_st)) & IM;
            m_st = ns;
        end
        #1;
        check("gpio_out", 32'(gpio_out), (m_out ^ OM) & OM);
        check("irq", 32'(irq), 32'(m_irq));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rvalid));
        check("rsp_data", rsp_data, m_rdata);
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d, input logic [1:0] sz);
        cmd_valid = 1; cmd_wr = 1; cmd_addr = a; cmd_data = d; cmd_size = sz;
        step();
        cmd_valid = 0; cmd_wr = 0;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] q);
        cmd_valid = 1; cmd_wr = 0; cmd_addr = a; cmd_size = 2;
        step();
        q = rsp_data;
        check("rd_valid", 32'(rsp_valid), 32'd1);
        cmd_valid = 0;
    endtask

    initial begin
        logic [31:0] q;
        reset_n = 0;
        step();
        step();
        check("rst_pins", 32'(gpio_out), 32'h7);
        check("rst_irq", 32'(irq), 32'd0);
        reset_n = 1;
        for (int a = 0; a < 16; a += 4) begin
            bus_rd(5'(a), q);
            check("rst_reg", q, 32'd0);
        end
        step();
        check("rvalid_idle", 32'(rsp_valid), 32'd0);

        bus_wr(5'd0, 32'h5, 2);
        bus_wr(5'd16, 32'h2, 2);
        bus_wr(5'd20, 32'h1, 2);
        bus_rd(5'd0, q);
        check("out_set_clr", q, 32'h6);
        check("pins_6", 32'(gpio_out), 32'h1);
        bus_wr(5'd1, 32'hFF, 0);
        bus_rd(5'd0, q);
        check("byte1_ignored", q, 32'h6);

`ifndef GPIO_DEBOUNCE_EN
        gpio_in = 1;
        step();
        step();
        bus_rd(5'd4, q);
        check("in_pre_edge3", q, 32'd0);
        bus_rd(5'd4, q);
        check("in_after_edge3", q, 32'd1);
        bus_rd(5'd8, q);
        check("edge_set", q, 32'd1);
        bus_wr(5'd12, 32'd1, 2);
        check("irq_same_edge", 32'(irq), 32'd0);
        step();
        check("irq_raised", 32'(irq), 32'd1);
        bus_wr(5'd8, 32'd1, 2);
        check("irq_hold_w1c", 32'(irq), 32'd1);
        step();
        check("irq_dropped", 32'(irq), 32'd0);
        gpio_in = 0;
        repeat (4) step();
        check("irq_fall_edge", 32'(irq), 32'd1);
        gpio_in = 1;
        step();
        step();
        bus_wr(5'd8, 32'd1, 2);
        step();
        check("irq_w1c_race", 32'(irq), 32'd1);
        bus_rd(5'd8, q);
        check("edge_w1c_race", q, 32'd1);
        bus_wr(5'd8, 32'd1, 2);
        step();
        step();
        check("irq_cleared", 32'(irq), 32'd0);
`else
        bus_wr(5'd12, 32'd1, 2);
        gpio_in = 1;
        repeat (10) step();
        gpio_in = 0;
        repeat (25) step();
        bus_rd(5'd4, q);
        check("pulse_in", q, 32'd0);
        bus_rd(5'd8, q);
        check("pulse_edge", q, 32'd0);
        gpio_in = 1;
        repeat (17) step();
        bus_rd(5'd4, q);
        check("lvl_pre18", q, 32'd0);
        bus_rd(5'd4, q);
        check("lvl_at18", q, 32'd1);
        check("lvl_irq", 32'(irq), 32'd1);
        bus_wr(5'd8, 32'd1, 2);
        step();
`endif

        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 7);
            cmd_valid = $urandom_range(0, 3) != 0;
            cmd_wr    = $urandom_range(0, 1) == 1;
            cmd_size  = 2'($urandom_range(0, 2));
            cmd_addr  = 5'(r * 4 + (cmd_size == 0 ? $urandom_range(0, 3) :
                                    cmd_size == 1 ? 2 * $urandom_range(0, 1) : 0));
            cmd_data  = $urandom;
            if ($urandom_range(0, 7) == 0) gpio_in = N_IN'($urandom);
            step();
        end
        cmd_valid = 0;
        reset_n = 0;
        step();
        check("mid_reset_rvalid", 32'(rsp_valid), 32'd0);
        check("mid_reset_pins", 32'(gpio_out), 32'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dbus_gpio.md
# dbus_gpio

Parametrised GPIO peripheral on the VexRiscv data bus, replacing the fixed LED/status decode with N outputs, M synchronised inputs, sticky edge flags and a level interrupt. Sits behind the top-level peripheral select (address bit 31) and shares the one-cycle, no-wait-state dBus response protocol of the on-chip RAM. The `irq` output drives `io_externalInterrupt`.

## Interface
- `N_OUT`, 3, number of output pins (1..32)
- `N_IN`, 1, number of input pins (1..32)
- `OUT_ACTIVE_LOW`, 1, pins driven as inverse of register bits
- `DEBOUNCE_CYCLES`, 16, stable cycles required before an input change is accepted (2..65535)
- `clk  in  1  system clock`
- `reset_n  in  1  synchronous, active-low reset`
- `cmd_valid  in  1  bus command valid, peripheral selected`
- `cmd_wr  in  1  1 = write, 0 = read`
- `cmd_addr  in  5  byte offset; bits [4:2] select register`
- `cmd_data  in  32  write data`
- `cmd_size  in  2  0 = byte, 1 = half, 2 = word`
- `rsp_valid  out  1  read data valid`
- `rsp_data  out  32  read data`
- `gpio_out  out  N_OUT  output pins`
- `gpio_in  in  N_IN  asynchronous input pins`
- `irq  out  1  level interrupt`

## Operation
- Registers (word offset): 0 OUT (RW), 1 IN (RO), 2 EDGE (W1C), 3 IRQ_EN (RW), 4 SET (WO, OR into OUT), 5 CLR (WO, AND-NOT into OUT), 6–7 reserved (read 0, writes ignored).
- Byte enables from `cmd_size`/`cmd_addr[1:0]` (0001/0011 shifted, or 1111) apply to OUT, IRQ_EN, EDGE, SET, CLR; unaligned sizes not checked.
- Bits above `N_OUT`/`N_IN` read 0, ignore writes. WO registers read 0.
- `gpio_out = OUT ^ {N_OUT{OUT_ACTIVE_LOW}}`.
- Input path: 2-FF synchroniser → `in_stable` (debounced, see Configuration) → EDGE bit i set whenever `in_stable[i]` changes (both edges).
- EDGE W1C and new edge on the same bit in the same cycle: flag remains set.
- `irq = |(EDGE & IRQ_EN)`, registered.
- Reset (`reset_n` low at `clk` edge): OUT=0 (pins = all-ones when active-low), IRQ_EN=0, EDGE=0, `in_stable`=0, synchroniser=0, debounce counters=0, `rsp_valid`=0, `rsp_data`=0, `irq`=0. Reset mid-transaction drops any pending response.
- After reset, edges caused by inputs already high at release are flagged; software clears EDGE before enabling.

## Timing
- Read: `cmd_valid && !cmd_wr` at edge k → `rsp_valid`=1 and `rsp_data` valid for exactly cycle k+1; data reflects register state before edge k. No wait states; back-to-back reads every cycle.
- Write: register updated at edge k; `gpio_out` changes at edge k (registered output); `irq` reflects new IRQ_EN/EDGE at edge k+1.
- `rsp_valid` is 0 after writes and idle cycles; `rsp_data` holds last value.
- Input latency without debounce: pin change → `in_stable`/EDGE at 3rd edge → `irq` at 4th.

## Configuration
- `GPIO_DEBOUNCE_EN` defined: per-input counter; counter resets to 0 whenever synchronised value equals `in_stable`, else increments; at `DEBOUNCE_CYCLES-1` `in_stable` takes the new value and counter clears. Glitches shorter than `DEBOUNCE_CYCLES` cycles are filtered. Latency = 2 + `DEBOUNCE_CYCLES` edges.
- Undefined: `in_stable <= sync[1]` every cycle; no counters; `DEBOUNCE_CYCLES` ignored.

## Structure
- Package `gpio_pkg`: register offset constants (`GPIO_REG_OUT`…`GPIO_REG_CLR`), size encodings, byte-enable function.
- Sub-module `gpio_debounce` (one input bit, counter width from `$clog2(DEBOUNCE_CYCLES)`), instantiated `N_IN` times under `GPIO_DEBOUNCE_EN`.

## Test plan
- Reset then read OUT, IN, EDGE, IRQ_EN → all 0; `gpio_out`=3'b111 with defaults; `rsp_valid` one cycle after each read.
- Write OUT=0x5, SET=0x2, CLR=0x1 → OUT reads 0x6, `gpio_out`=3'b001.
- Byte write 0xFF to offset 0 byte 1 (size 0, addr 0x01) → OUT unchanged.
- Debounce off: raise `gpio_in[0]` → IN=1 and EDGE=1 at 3rd edge; IRQ_EN=1 → `irq`=1 next cycle; W1C EDGE=1 → `irq` drops one cycle after.
- W1C EDGE bit 0 in the same cycle `in_stable[0]` toggles → EDGE stays 1, `irq` stays 1.
- `GPIO_DEBOUNCE_EN`, DEBOUNCE_CYCLES=16: 10-cycle pulse → no IN/EDGE change; 20-cycle level → IN=1 at edge 18 after pin change.
